// File: rtl/clkgen_pkg.sv
// Shared constants and the divisor type for the system-clock generator.
// The address-decode register block imports this so it drives div_data with the same type.
package clkgen_pkg;

  localparam int unsigned CLKGEN_DIV_WIDTH   = 8;
  localparam int unsigned CLKGEN_DEFAULT_DIV = 8;
  localparam int unsigned CLKGEN_MIN_DIV     = 2;

  typedef logic [CLKGEN_DIV_WIDTH-1:0] clkgen_div_t;

endpackage

// File: rtl/clkgen.sv
// Run-time programmable divider for the 6502 system clock, with a clock stretch input and edge strobes.
// Each period is a low phase of N - N/2 cycles followed by a high phase of N/2 cycles.
module clkgen
  import clkgen_pkg::*;
#(
  parameter int unsigned DIV_WIDTH   = CLKGEN_DIV_WIDTH,
  parameter int unsigned DEFAULT_DIV = CLKGEN_DEFAULT_DIV
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 div_wr,
  input  logic [DIV_WIDTH-1:0] div_data,
  input  logic                 stretch,
  output logic                 clockout,
  output logic                 rise,
  output logic                 fall,
  output logic                 div_pending,
  output logic [DIV_WIDTH-1:0] div_current
);

  typedef logic [DIV_WIDTH-1:0] div_t;

  localparam div_t DEFAULT_VAL = div_t'(DEFAULT_DIV);
  localparam div_t MIN_VAL     = div_t'(CLKGEN_MIN_DIV);
  localparam div_t ONE         = div_t'(1);

  div_t cnt;
  div_t cnt_next;
  div_t pending_div;
  div_t low_len;
  div_t wr_value;
  logic at_end;
  logic wrap;
  logic apply;
  logic clk_next;

  always_comb begin
    // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
    low_len  = div_current - (div_current >> 1);
    at_end   = (cnt == div_current - ONE);
    wrap     = at_end && !stretch;
    apply    = wrap && div_pending && !div_wr;
    wr_value = (div_data < MIN_VAL) ? MIN_VAL : div_data;

    cnt_next = cnt + ONE;
    if (wrap) begin
      cnt_next = '0;
    end else if (at_end) begin
      cnt_next = cnt;
    end

    // At a wrap cnt_next is 0, which is always in the low phase, so the old divisor's low_len is safe here.
    clk_next = (cnt_next >= low_len);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      clockout    <= 1'b0;
      rise        <= 1'b0;
      fall        <= 1'b0;
      pending_div <= '0;
      div_pending <= 1'b0;
      div_current <= DEFAULT_VAL;
    end else begin
      // NOTE: non-blocking assignments, so every register here sees the pre-edge value of the others.
      cnt      <= cnt_next;
      clockout <= clk_next;
      rise     <= clk_next & ~clockout;
      fall     <= ~clk_next & clockout;

      // A write on the boundary cycle replaces the pending value, so the swap is deferred one period.
      if (div_wr) begin
        pending_div <= wr_value;
        div_pending <= 1'b1;
      end else if (apply) begin
        div_current <= pending_div;
        div_pending <= 1'b0;
      end
    end
  end

endmodule
